// File: rtl/tx_sched_pkg.sv
// Shared types and timebase constants for the transmit scheduler.
// Frame = 12 bit slots of 32 cycles, a 128-cycle SYNC and one IDLE cycle.
package tx_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_LAST = 2'd2
    } sched_state_t;

    localparam int unsigned BIT_LAST     = 31;
    localparam int unsigned SYNC_LAST    = 127;
    localparam int unsigned FRAME_CYCLES = 513;

endpackage

// File: rtl/tx_frame_sched_rr_arbiter.sv
// Purpose: one-hot grant plus index; round-robin, or fixed lowest-index with TX_SCHED_FIXED_PRIO_EN.
// Latency: combinational grant; pointer moves on the clock edge that takes the grant.
// Backpressure: none; advance_i is asserted only when the grant is consumed.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
`ifndef TX_SCHED_FIXED_PRIO_EN
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            advance_i,
`endif
    input  logic [NREQ-1:0] req_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IDW-1:0]  idx_o
);

    logic [IDW-1:0] ptr_q;
    logic [IDW-1:0] idx_hi;
    logic [IDW-1:0] idx_lo;
    logic           found_hi;
    logic           found_lo;

    // Lowest requester at or above the pointer wins; otherwise wrap to the lowest overall.
    always_comb begin
        idx_hi   = '0;
        idx_lo   = '0;
        found_hi = 1'b0;
        found_lo = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_lo   = IDW'(i);
                found_lo = 1'b1;
                if (IDW'(i) >= ptr_q) begin
                    idx_hi   = IDW'(i);
                    found_hi = 1'b1;
                end
            end
        end
        idx_o = found_hi ? idx_hi : idx_lo;
        gnt_o = '0;
        for (int i = 0; i < NREQ; i++) begin
            gnt_o[i] = found_lo && (idx_o == IDW'(i));
        end
    end

`ifdef TX_SCHED_FIXED_PRIO_EN
    assign ptr_q = '0;
`else
    logic [IDW-1:0] ptr_d;

    assign ptr_d = (idx_o == IDW'(NREQ - 1)) ? '0 : idx_o + 1'b1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else if (advance_i) begin
            ptr_q <= ptr_d;
        end
    end
`endif

endmodule

// File: rtl/tx_frame_sched.sv
// Purpose: arbitrates requesters, loads the fsm_cod encoder and repeats each word REPEATS frames;
// owns the bit/sync timebase. Latency: grant is combinational, encoder regs load on the grant edge.
// Backpressure: requesters hold req_valid until granted. TX_SCHED_FIXED_PRIO_EN selects fixed priority.
module tx_frame_sched
    import tx_sched_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int REPEATS = 4
) (
    input  logic                    clk_12kHz,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [8*NREQ-1:0]       req_a01,
    input  logic [8*NREQ-1:0]       req_af,
    input  logic [4*NREQ-1:0]       req_data,
    output logic [NREQ-1:0]         req_gnt,
    output logic                    enc_rst,
    output logic [7:0]              enc_a01,
    output logic [7:0]              enc_af,
    output logic [3:0]              enc_dado,
    input  logic                    enc_start_count,
    input  logic                    enc_start_sync,
    input  logic                    enc_sync_flag,
    output logic [4:0]              bit_count,
    output logic                    bit_fim,
    output logic [6:0]              sync_count,
    output logic                    sync_fim,
    output logic                    busy,
    output logic                    word_done,
    output logic [$clog2(NREQ)-1:0] active_id
);

    localparam int IDW = $clog2(NREQ);

    logic [4:0]     bit_count_q, bit_count_d;
    logic [6:0]     sync_count_q, sync_count_d;
    logic           sync_flag_q;
    sched_state_t   state_q, state_d;
    logic [3:0]     rep_left_q, rep_left_d;
    logic           enc_rst_q, enc_rst_d;
    logic [7:0]     enc_a01_q, enc_a01_d;
    logic [7:0]     enc_af_q, enc_af_d;
    logic [3:0]     enc_dado_q, enc_dado_d;
    logic [IDW-1:0] active_id_q, active_id_d;

    logic [NREQ-1:0] arb_gnt;
    logic [IDW-1:0]  arb_idx;
    logic            any_req;
    logic            sync_rise;
    logic            last_rep;
    logic            grant_en;

    assign bit_count_d  = enc_start_count ? bit_count_q + 5'd1 : 5'd0;
    assign sync_count_d = enc_start_sync ? sync_count_q + 7'd1 : 7'd0;
    assign bit_fim      = enc_start_count & (bit_count_q == 5'(BIT_LAST));
    assign sync_fim     = enc_start_sync & (sync_count_q == 7'(SYNC_LAST));
    assign sync_rise    = enc_sync_flag & ~sync_flag_q;

    assign any_req  = |req_valid;
    assign last_rep = (rep_left_q == 4'd0);
    // A new word is taken from IDLE at once, or at the SYNC edge ending the last repetition.
    assign grant_en = any_req & ((state_q == S_IDLE) |
                                 ((state_q == S_RUN) & sync_rise & last_rep));

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
`ifndef TX_SCHED_FIXED_PRIO_EN
        .clk_i     (clk_12kHz),
        .rst_ni    (rst_n),
        .advance_i (grant_en),
`endif
        .req_i     (req_valid),
        .gnt_o     (arb_gnt),
        .idx_o     (arb_idx)
    );

    always_comb begin
        state_d     = state_q;
        rep_left_d  = rep_left_q;
        enc_rst_d   = enc_rst_q;
        enc_a01_d   = enc_a01_q;
        enc_af_d    = enc_af_q;
        enc_dado_d  = enc_dado_q;
        active_id_d = active_id_q;
        if (grant_en) begin
            enc_a01_d   = req_a01[8*arb_idx +: 8];
            enc_af_d    = req_af[8*arb_idx +: 8];
            enc_dado_d  = req_data[4*arb_idx +: 4];
            active_id_d = arb_idx;
            rep_left_d  = 4'(REPEATS - 1);
            enc_rst_d   = 1'b0;
            state_d     = S_RUN;
        end else begin
            case (state_q)
                S_IDLE: enc_rst_d = 1'b1;
                S_RUN: begin
                    if (sync_rise) begin
                        if (!last_rep) rep_left_d = rep_left_q - 4'd1;
                        else           state_d    = S_LAST;
                    end
                end
                S_LAST: begin
                    if (sync_fim) begin
                        enc_rst_d = 1'b1;
                        state_d   = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_12kHz or negedge rst_n) begin
        if (!rst_n) begin
            bit_count_q  <= '0;
            sync_count_q <= '0;
            sync_flag_q  <= 1'b0;
            state_q      <= S_IDLE;
            rep_left_q   <= '0;
            enc_rst_q    <= 1'b1;
            enc_a01_q    <= '0;
            enc_af_q     <= '0;
            enc_dado_q   <= '0;
            active_id_q  <= '0;
        end else begin
            bit_count_q  <= bit_count_d;
            sync_count_q <= sync_count_d;
            sync_flag_q  <= enc_sync_flag;
            state_q      <= state_d;
            rep_left_q   <= rep_left_d;
            enc_rst_q    <= enc_rst_d;
            enc_a01_q    <= enc_a01_d;
            enc_af_q     <= enc_af_d;
            enc_dado_q   <= enc_dado_d;
            active_id_q  <= active_id_d;
        end
    end

    assign req_gnt    = grant_en ? arb_gnt : '0;
    assign word_done  = (state_q == S_RUN) & sync_rise & last_rep;
    assign busy       = (state_q != S_IDLE);
    assign enc_rst    = enc_rst_q;
    assign enc_a01    = enc_a01_q;
    assign enc_af     = enc_af_q;
    assign enc_dado   = enc_dado_q;
    assign bit_count  = bit_count_q;
    assign sync_count = sync_count_q;
    assign active_id  = active_id_q;

endmodule

// File: tb/tb_tx_frame_sched.sv
// Directed bench for tx_frame_sched with a behavioural fsm_cod timing model driving the status inputs.
// Expected grant order follows TX_SCHED_FIXED_PRIO_EN when that macro is defined.
module tb_tx_frame_sched;

    localparam int NREQ    = 4;
    localparam int REPEATS = 4;

    logic              clk_12kHz = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_a01;
    logic [8*NREQ-1:0] req_af;
    logic [4*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_gnt;
    logic              enc_rst;
    logic [7:0]        enc_a01, enc_af;
    logic [3:0]        enc_dado;
    logic              enc_start_count, enc_start_sync, enc_sync_flag;
    logic [4:0]        bit_count;
    logic              bit_fim;
    logic [6:0]        sync_count;
    logic              sync_fim;
    logic              busy, word_done;
    logic [1:0]        active_id;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    tx_frame_sched #(.NREQ(NREQ), .REPEATS(REPEATS)) dut (
        .clk_12kHz       (clk_12kHz),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_a01         (req_a01),
        .req_af          (req_af),
        .req_data        (req_data),
        .req_gnt         (req_gnt),
        .enc_rst         (enc_rst),
        .enc_a01         (enc_a01),
        .enc_af          (enc_af),
        .enc_dado        (enc_dado),
        .enc_start_count (enc_start_count),
        .enc_start_sync  (enc_start_sync),
        .enc_sync_flag   (enc_sync_flag),
        .bit_count       (bit_count),
        .bit_fim         (bit_fim),
        .sync_count      (sync_count),
        .sync_fim        (sync_fim),
        .busy            (busy),
        .word_done       (word_done),
        .active_id       (active_id)
    );

    always #5 clk_12kHz = ~clk_12kHz;
    always @(posedge clk_12kHz) cyc <= cyc + 1;

    // Encoder model: 0 = IDLE, 1..12 = A0..D3 slots, 13 = SYNC; one settle cycle after reset release.
    int   es   = 0;
    logic hold = 1'b1;
    always @(posedge clk_12kHz or posedge enc_rst) begin
        if (enc_rst) begin
            es   <= 0;
            hold <= 1'b1;
        end else if (hold) begin
            hold <= 1'b0;
        end else if (es == 0) begin
            es <= 1;
        end else if (es <= 12) begin
            if (bit_fim) es <= es + 1;
        end else if (sync_fim) begin
            es <= 0;
        end
    end
    assign enc_start_count = (es >= 1) && (es <= 12);
    assign enc_start_sync  = (es == 13);
    assign enc_sync_flag   = (es == 13);

    logic flag_d = 1'b0;
    logic tb_rise;
    always @(posedge clk_12kHz) flag_d <= enc_sync_flag;
    assign tb_rise = enc_sync_flag & ~flag_d;

    task automatic apply_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        repeat (2) @(negedge clk_12kHz);
        rst_n = 1'b1;
        @(negedge clk_12kHz);
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        req_a01   = '0;
        req_af    = '0;
        req_data  = '0;
        #12;
        n_cmp++; if ({enc_rst, busy, word_done, bit_fim, sync_fim} !== 5'b10000) begin
            n_bad++; $display("FAIL reset_flags: got %b want 10000", {enc_rst, busy, word_done, bit_fim, sync_fim}); end
        n_cmp++; if ({enc_a01, enc_af, enc_dado} !== 20'h0) begin
            n_bad++; $display("FAIL reset_enc_regs: got %h want 00000", {enc_a01, enc_af, enc_dado}); end
        n_cmp++; if ({bit_count, sync_count, active_id, req_gnt} !== 18'h0) begin
            n_bad++; $display("FAIL reset_counts: got %h want 0", {bit_count, sync_count, active_id, req_gnt}); end
        @(negedge clk_12kHz);
        rst_n = 1'b1;
        repeat (5) @(negedge clk_12kHz);
        n_cmp++; if ({enc_rst, busy, req_gnt, bit_count} !== {1'b1, 1'b0, 4'b0, 5'd0}) begin
            n_bad++; $display("FAIL idle_hold: got %b want 1000000000", {enc_rst, busy, req_gnt, bit_count}); end
    endtask

    task automatic test_single_word();
        int k, rises, wd, hold_bad, rst_bad, late_t;
        logic [3:0] late_g;
        rises = 0; wd = 0; hold_bad = 0; rst_bad = 0; late_t = -1; late_g = '0;
        apply_reset();
        req_a01[23:16] = 8'hA5;
        req_af[23:16]  = 8'h00;
        req_data[11:8] = 4'h9;
        req_valid      = 4'b0100;
        #1;
        n_cmp++; if (req_gnt !== 4'b0100) begin
            n_bad++; $display("FAIL sw_gnt: got %b want 0100", req_gnt); end
        @(negedge clk_12kHz);
        k = cyc;
        n_cmp++; if ({enc_rst, busy, active_id, req_gnt} !== {1'b0, 1'b1, 2'd2, 4'b0}) begin
            n_bad++; $display("FAIL sw_load: got %b want 01100000", {enc_rst, busy, active_id, req_gnt}); end
        for (int t = 0; t <= 2053; t++) begin
            if (t != 0) @(negedge clk_12kHz);
            if (t >= 1 && req_gnt !== '0 && late_t < 0) begin late_t = t; late_g = req_gnt; end
            if (t >= 2 && t <= 33) begin
                n_cmp++; if ({bit_count, bit_fim} !== {5'(t - 2), 1'(t == 33)}) begin
                    n_bad++; $display("FAIL bit_counter t=%0d: got %0d/%b want %0d/%b", t, bit_count, bit_fim, t - 2, t == 33); end
            end
            if (t >= 386 && t <= 513) begin
                n_cmp++; if ({sync_count, sync_fim} !== {7'(t - 386), 1'(t == 513)}) begin
                    n_bad++; $display("FAIL sync_counter t=%0d: got %0d/%b want %0d/%b", t, sync_count, sync_fim, t - 386, t == 513); end
            end
            if (tb_rise) begin
                rises++;
                n_cmp++; if (t !== 386 + 513 * (rises - 1)) begin
                    n_bad++; $display("FAIL sw_rise_time: got %0d want %0d", t, 386 + 513 * (rises - 1)); end
                n_cmp++; if (word_done !== 1'(rises == 4)) begin
                    n_bad++; $display("FAIL sw_word_done rise %0d: got %b want %b", rises, word_done, rises == 4); end
            end
            if (word_done) wd++;
            if (t <= 2052 && {enc_a01, enc_af, enc_dado} !== {8'hA5, 8'h00, 4'h9}) hold_bad++;
            if (t <= 2052 && (enc_rst !== 1'b0 || busy !== 1'b1)) rst_bad++;
            if (t == 2053) begin
                n_cmp++; if ({enc_rst, busy} !== 2'b10) begin
                    n_bad++; $display("FAIL sw_back_to_idle: got %b want 10", {enc_rst, busy}); end
            end
            if (t == 0)    req_valid[2] = 1'b0;
            if (t == 1000) req_valid[0] = 1'b1;
            if (t == 1100) req_valid[0] = 1'b0;
            if (t == 1935) req_valid[3] = 1'b1;
        end
        n_cmp++; if (rises !== 4) begin n_bad++; $display("FAIL sw_rises: got %0d want 4", rises); end
        n_cmp++; if (wd !== 1) begin n_bad++; $display("FAIL sw_word_done_count: got %0d want 1", wd); end
        n_cmp++; if (hold_bad !== 0) begin n_bad++; $display("FAIL sw_payload_stable: got %0d bad cycles want 0", hold_bad); end
        n_cmp++; if (rst_bad !== 0) begin n_bad++; $display("FAIL sw_enc_rst_low: got %0d bad cycles want 0", rst_bad); end
        n_cmp++; if (late_t !== 2053 || late_g !== 4'b1000) begin
            n_bad++; $display("FAIL sw_last_waits: got t=%0d gnt=%b want t=2053 gnt=1000", late_t, late_g); end
    endtask

    task automatic test_back_to_back();
        int ngnt, rises, wd, rst_bad;
        logic [3:0] exp2;
        logic [1:0] exp_id;
        logic [7:0] exp_a;
        ngnt = 0; rises = 0; wd = 0; rst_bad = 0;
`ifdef TX_SCHED_FIXED_PRIO_EN
        exp2 = 4'b0001; exp_id = 2'd0; exp_a = 8'h11;
`else
        exp2 = 4'b0010; exp_id = 2'd1; exp_a = 8'h22;
`endif
        apply_reset();
        req_a01[7:0] = 8'h11; req_data[3:0] = 4'h1;
        req_a01[15:8] = 8'h22; req_data[7:4] = 4'h2;
        req_af = '0;
        req_valid = 4'b0011;
        #1;
        n_cmp++; if (req_gnt !== 4'b0001) begin n_bad++; $display("FAIL b2b_first_gnt: got %b want 0001", req_gnt); end
        @(negedge clk_12kHz);
        for (int t = 0; t <= 4105; t++) begin
            if (t != 0) @(negedge clk_12kHz);
            if (t == 0) begin
                n_cmp++; if ({active_id, enc_a01} !== {2'd0, 8'h11}) begin
                    n_bad++; $display("FAIL b2b_word0: got %h want 011", {active_id, enc_a01}); end
            end
            if (t > 0 && req_gnt !== '0) begin
                ngnt++;
                n_cmp++; if (t !== 1925 || req_gnt !== exp2 || active_id !== 2'd0) begin
                    n_bad++; $display("FAIL b2b_second_gnt: got t=%0d gnt=%b id=%0d want t=1925 gnt=%b id=0", t, req_gnt, active_id, exp2); end
            end
            if (t == 1926) begin
                n_cmp++; if ({active_id, enc_a01} !== {exp_id, exp_a}) begin
                    n_bad++; $display("FAIL b2b_switch: got %h want %h", {active_id, enc_a01}, {exp_id, exp_a}); end
                req_valid = '0;
            end
            if (tb_rise) begin
                rises++;
                n_cmp++; if (word_done !== 1'(rises == 4 || rises == 8)) begin
                    n_bad++; $display("FAIL b2b_word_done rise %0d: got %b", rises, word_done); end
            end
            if (word_done) wd++;
            if (t <= 4104 && enc_rst !== 1'b0) rst_bad++;
            if (t == 4105) begin
                n_cmp++; if (enc_rst !== 1'b1) begin n_bad++; $display("FAIL b2b_final_rst: got %b want 1", enc_rst); end
            end
        end
        n_cmp++; if (ngnt !== 1) begin n_bad++; $display("FAIL b2b_gnt_count: got %0d want 1", ngnt); end
        n_cmp++; if (rises !== 8 || wd !== 2) begin n_bad++; $display("FAIL b2b_rises: got %0d/%0d want 8/2", rises, wd); end
        n_cmp++; if (rst_bad !== 0) begin n_bad++; $display("FAIL b2b_no_enc_rst: got %0d cycles want 0", rst_bad); end
    endtask

    task automatic test_round_robin();
        int n, exp_t;
        logic [3:0] exp_g;
        n = 0;
        apply_reset();
        req_valid = 4'b1111;
        #1;
        for (int t = 0; t <= 14300; t++) begin
            if (t != 0) @(negedge clk_12kHz);
            if (req_gnt !== '0 && n < 8) begin
`ifdef TX_SCHED_FIXED_PRIO_EN
                exp_g = 4'b0001;
`else
                exp_g = 4'b0001 << (n % 4);
`endif
                exp_t = (n == 0) ? 0 : 1926 + 2052 * (n - 1);
                n_cmp++; if (req_gnt !== exp_g || t !== exp_t) begin
                    n_bad++; $display("FAIL rr_grant %0d: got %b at t=%0d want %b at t=%0d", n, req_gnt, t, exp_g, exp_t); end
                n++;
                if (n == 8) req_valid = '0;
            end
        end
        n_cmp++; if (n !== 8) begin n_bad++; $display("FAIL rr_grant_count: got %0d want 8", n); end
    endtask

    task automatic test_reset_mid_word();
        int wd, rst_bad, first_rise;
        wd = 0; rst_bad = 0; first_rise = -1;
        apply_reset();
        req_a01[31:24] = 8'h00; req_af[31:24] = 8'h01; req_data[15:12] = 4'h6;
        req_valid = 4'b1000;
        #1;
        n_cmp++; if (req_gnt !== 4'b1000) begin n_bad++; $display("FAIL float_gnt: got %b want 1000", req_gnt); end
        @(negedge clk_12kHz);
        n_cmp++; if ({enc_af, enc_a01, enc_dado, active_id} !== {8'h01, 8'h00, 4'h6, 2'd3}) begin
            n_bad++; $display("FAIL float_load: got %h want 0100063", {enc_af, enc_a01, enc_dado, active_id}); end
        req_valid = '0;
        for (int t = 1; t <= 715; t++) begin
            @(negedge clk_12kHz);
            if (word_done) wd++;
        end
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({enc_rst, busy, word_done, active_id} !== 5'b10000) begin
            n_bad++; $display("FAIL mid_rst_flags: got %b want 10000", {enc_rst, busy, word_done, active_id}); end
        n_cmp++; if ({enc_af, enc_a01, enc_dado, bit_count, sync_count} !== 32'h0) begin
            n_bad++; $display("FAIL mid_rst_regs: got %h want 0", {enc_af, enc_a01, enc_dado, bit_count, sync_count}); end
        n_cmp++; if (wd !== 0) begin n_bad++; $display("FAIL mid_rst_no_done: got %0d want 0", wd); end
        @(negedge clk_12kHz);
        rst_n = 1'b1;
        @(negedge clk_12kHz);
        req_a01[15:8] = 8'h3C;
        req_valid = 4'b0010;
        #1;
        n_cmp++; if (req_gnt !== 4'b0010) begin n_bad++; $display("FAIL restart_gnt: got %b want 0010", req_gnt); end
        @(negedge clk_12kHz);
        req_valid = '0;
        for (int t = 0; t <= 386; t++) begin
            if (t != 0) @(negedge clk_12kHz);
            if (t == 2) begin
                n_cmp++; if ({enc_start_count, bit_count, bit_fim} !== {1'b1, 5'd0, 1'b0}) begin
                    n_bad++; $display("FAIL restart_a0: got %b want 1000000", {enc_start_count, bit_count, bit_fim}); end
            end
            if (tb_rise && first_rise < 0) first_rise = t;
            if (enc_rst !== 1'b0) rst_bad++;
        end
        n_cmp++; if (first_rise !== 386 || rst_bad !== 0) begin
            n_bad++; $display("FAIL restart_frame: got rise=%0d rst_bad=%0d want 386/0", first_rise, rst_bad); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d compared", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_round_robin();
        test_reset_mid_word();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
